// File: rtl/audio_pkg.sv
// Purpose : shared types and constants for the audio sample pacer.
// Latency : n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package audio_pkg;

    // One PCM sample word, two's complement.
    typedef logic signed [15:0] sample_t;

    // Playback state machine encoding.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PLAY     = 2'd1,
        ST_UNDERRUN = 2'd2
    } state_t;

    // Pixel-clock cycles per 48 kHz sample period for common video modes.
    localparam int DIV_720P  = 1562;
    localparam int DIV_1080P = 3125;

    // One step of the underrun fade: halve the sample, keeping its sign,
    // so a held value decays toward 0 (positive) or -1 (negative).
    function automatic sample_t fade_step(input sample_t s);
        return s >>> 1;
    endfunction

endpackage

// File: rtl/audio_tick_gen.sv
// Purpose : free-running sample-rate divider producing a one-cycle tick and a ~50% audio clock.
// Latency : tick is combinational from the counter; clk_audio is registered.
// Backpressure: none; runs every clk_pixel cycle regardless of downstream state.
//
// Ports:
//   clk_pixel  - sole clock, rising edge
//   reset_n    - synchronous active-low reset
//   tick       - high for the one cycle where the counter equals DIV-1
//   clk_audio  - high while the counter is in the upper half of its range
module audio_tick_gen #(
    parameter int DIV = 1562
) (
    input  logic clk_pixel,
    input  logic reset_n,
    output logic tick,
    output logic clk_audio
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2);

    logic [CNT_W-1:0] counter_q;
    logic [CNT_W-1:0] counter_d;
    logic             clk_audio_q;
    logic             clk_audio_d;

    always_comb begin
        counter_d   = (counter_q == CNT_LAST) ? '0 : counter_q + CNT_W'(1);
        // Compare against the next count so clk_audio is aligned with counter_q.
        clk_audio_d = (counter_d >= CNT_HALF);
    end

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            counter_q   <= '0;
            clk_audio_q <= 1'b0;
        end else begin
            counter_q   <= counter_d;
            clk_audio_q <= clk_audio_d;
        end
    end

    assign tick      = (counter_q == CNT_LAST);
    assign clk_audio = clk_audio_q;

endmodule

// File: rtl/audio_sample_pacer.sv
// Purpose : paces stereo samples out of an external FIFO at the audio sample rate (IDLE/PLAY/UNDERRUN).
// Latency : fifo_rden on the tick cycle, samples and strobe visible 2 cycles after the tick.
// Backpressure: reads only when the FIFO is non-empty; an empty FIFO on a tick counts an underrun.
//
// Ports:
//   clk_pixel, reset_n         - clock and synchronous active-low reset
//   enable                     - playback enable; low forces IDLE and zero samples
//   fifo_q/fifo_empty/level    - FIFO read data ([31:16] right, [15:0] left), empty flag, word count
//   fifo_rden                  - one-cycle FIFO read pulse (read latency 1)
//   clk_audio                  - derived sample clock
//   sample_left/right, strobe  - current samples and their update pulse
//   underrun_count, playing    - saturating underrun counter, high in PLAY
// Build option: define AUDIO_FADE_EN to decay held samples by half on each underrun tick.
module audio_sample_pacer
    import audio_pkg::*;
#(
    parameter int DIV     = 1562,
    parameter int PREFILL = 256,
    parameter int LEVEL_W = 11
) (
    input  logic               clk_pixel,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [31:0]        fifo_q,
    input  logic               fifo_empty,
    input  logic [LEVEL_W-1:0] fifo_level,
    output logic               fifo_rden,
    output logic               clk_audio,
    output logic [15:0]        sample_left,
    output logic [15:0]        sample_right,
    output logic               sample_strobe,
    output logic [15:0]        underrun_count,
    output logic               playing
);

    localparam logic [LEVEL_W-1:0] PREFILL_LVL = LEVEL_W'(PREFILL);

    logic tick;

    audio_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .tick      (tick),
        .clk_audio (clk_audio)
    );

    state_t      state_q,          state_d;
    sample_t     left_q,           left_d;
    sample_t     right_q,          right_d;
    logic        strobe_q,         strobe_d;
    logic        rd_pend_q,        rd_pend_d;
    logic        playing_q,        playing_d;
    logic [15:0] underrun_count_q, underrun_count_d;
    logic        rden_c;

    always_comb begin
        state_d          = state_q;
        left_d           = left_q;
        right_d          = right_q;
        strobe_d         = 1'b0;
        rd_pend_d        = 1'b0;
        underrun_count_d = underrun_count_q;
        rden_c           = 1'b0;

        if (!enable) begin
            // Disable wins over a coincident tick and drops any read in flight.
            state_d = ST_IDLE;
            left_d  = '0;
            right_d = '0;
        end else begin
            // Data requested last cycle is on fifo_q now.
            if (rd_pend_q) begin
                left_d   = sample_t'(fifo_q[15:0]);
                right_d  = sample_t'(fifo_q[31:16]);
                strobe_d = 1'b1;
            end

            if (tick) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (!fifo_empty && (fifo_level >= PREFILL_LVL)) begin
                            rden_c  = 1'b1;
                            state_d = ST_PLAY;
                        end
                    end
                    ST_PLAY, ST_UNDERRUN: begin
                        if (!fifo_empty) begin
                            rden_c  = 1'b1;
                            state_d = ST_PLAY;
                        end else begin
                            state_d = ST_UNDERRUN;
                            if (underrun_count_q != 16'hFFFF) begin
                                underrun_count_d = underrun_count_q + 16'd1;
                            end
`ifdef AUDIO_FADE_EN
                            left_d   = fade_step(left_q);
                            right_d  = fade_step(right_q);
                            strobe_d = 1'b1;
`endif
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end

            rd_pend_d = rden_c;
        end

        playing_d = (state_d == ST_PLAY);
    end

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            left_q           <= '0;
            right_q          <= '0;
            strobe_q         <= 1'b0;
            rd_pend_q        <= 1'b0;
            playing_q        <= 1'b0;
            underrun_count_q <= '0;
        end else begin
            state_q          <= state_d;
            left_q           <= left_d;
            right_q          <= right_d;
            strobe_q         <= strobe_d;
            rd_pend_q        <= rd_pend_d;
            playing_q        <= playing_d;
            underrun_count_q <= underrun_count_d;
        end
    end

    // The read must land on the tick cycle itself, so it is decoded from the
    // current tick/enable/empty rather than registered; reset masks it.
    assign fifo_rden      = rden_c & reset_n;
    assign sample_left    = left_q;
    assign sample_right   = right_q;
    assign sample_strobe  = strobe_q;
    assign underrun_count = underrun_count_q;
    assign playing        = playing_q;

endmodule

// File: tb/tb_audio_sample_pacer.sv
module tb_audio_sample_pacer;

    localparam int DIV     = 8;
    localparam int PREFILL = 4;
    localparam int LEVEL_W = 11;

    logic               clk_pixel = 1'b0;
    logic               reset_n;
    logic               enable;
    logic [31:0]        fifo_q;
    logic               fifo_empty;
    logic [LEVEL_W-1:0] fifo_level;
    logic               fifo_rden;
    logic               clk_audio;
    logic [15:0]        sample_left;
    logic [15:0]        sample_right;
    logic               sample_strobe;
    logic [15:0]        underrun_count;
    logic               playing;

    audio_sample_pacer #(
        .DIV     (DIV),
        .PREFILL (PREFILL),
        .LEVEL_W (LEVEL_W)
    ) dut (
        .clk_pixel      (clk_pixel),
        .reset_n        (reset_n),
        .enable         (enable),
        .fifo_q         (fifo_q),
        .fifo_empty     (fifo_empty),
        .fifo_level     (fifo_level),
        .fifo_rden      (fifo_rden),
        .clk_audio      (clk_audio),
        .sample_left    (sample_left),
        .sample_right   (sample_right),
        .sample_strobe  (sample_strobe),
        .underrun_count (underrun_count),
        .playing        (playing)
    );

    always #5 clk_pixel = ~clk_pixel;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Bench-side FIFO with read latency 1.
    logic [31:0] fq[$];
    logic [31:0] q_next = 32'h0;

    // Reference model: position in the sample period, playback mode
    // (0 idle, 1 playing, 2 starved), pending read, and expected outputs.
    bit          m_valid = 1'b0;
    int          m_cnt;
    int          m_mode;
    bit          m_pend;
    logic [15:0] m_l, m_r;
    bit          m_strobe;
    int          m_count;
    bit          m_rd;

    bit rst_drv     = 1'b0;
    int rd_seen     = 0;
    int strobe_seen = 0;
    int hi_seen     = 0;
    int rise_seen   = 0;
    bit clk_prev    = 1'b0;

    // One clock cycle: check registered outputs, drive inputs, predict, check read.
    task automatic step(input bit en);
        @(negedge clk_pixel);
        if (m_valid) begin
            chk("strobe",    {31'b0, sample_strobe}, {31'b0, m_strobe});
            chk("left",      {16'b0, sample_left},  {16'b0, m_l});
            chk("right",     {16'b0, sample_right}, {16'b0, m_r});
            chk("playing",   {31'b0, playing}, {31'b0, (m_mode == 1)});
            chk("count",     {16'b0, underrun_count}, m_count);
            chk("clk_audio", {31'b0, clk_audio}, {31'b0, (m_cnt >= DIV / 2)});
        end
        if (sample_strobe) strobe_seen++;
        if (clk_audio) hi_seen++;
        if (clk_audio && !clk_prev) rise_seen++;
        clk_prev = clk_audio;

        reset_n    = rst_drv;
        enable     = en;
        fifo_q     = q_next;
        fifo_empty = (fq.size() == 0);
        fifo_level = LEVEL_W'(fq.size());
        #1;

        if (!rst_drv) begin
            m_cnt = 0; m_mode = 0; m_pend = 0; m_l = '0; m_r = '0;
            m_strobe = 0; m_count = 0; m_rd = 0; m_valid = 1'b1;
        end else begin
            m_rd = 0;
            if (!en) begin
                m_mode = 0; m_l = '0; m_r = '0; m_strobe = 0; m_pend = 0;
            end else begin
                m_strobe = 0;
                if (m_pend) begin
                    m_l = fifo_q[15:0];
                    m_r = fifo_q[31:16];
                    m_strobe = 1;
                end
                m_pend = 0;
                if (m_cnt == DIV - 1) begin
                    if (!fifo_empty && (m_mode != 0 || fifo_level >= PREFILL)) begin
                        m_rd = 1; m_mode = 1; m_pend = 1;
                    end else if (m_mode != 0) begin
                        m_mode = 2;
                        if (m_count < 65535) m_count++;
`ifdef AUDIO_FADE_EN
                        m_l = $signed(m_l) >>> 1;
                        m_r = $signed(m_r) >>> 1;
                        m_strobe = 1;
`endif
                    end
                end
            end
            m_cnt = (m_cnt + 1) % DIV;
        end

        chk("rden", {31'b0, fifo_rden}, {31'b0, m_rd});
        if (fifo_rden) begin
            rd_seen++;
            chk("rden_on_empty", {31'b0, fifo_empty}, 32'd0);
            if (fq.size() != 0) q_next = fq.pop_front();
        end
    endtask

    // Run until n sample periods have ticked, one more cycle, then view the
    // state two cycles after the last tick.
    task automatic run_ticks(input int n, input bit en);
        int k = 0;
        while (k < n) begin
            bit t = (m_cnt == DIV - 1);
            step(en);
            if (t) k++;
        end
        step(en);
        @(posedge clk_pixel);
        #1;
    endtask

    typedef struct {
        int          ticks;
        int          push_n;
        logic [31:0] word;
        int          exp_rd;
        logic        exp_play;
        logic [15:0] exp_cnt;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
        logic        exp_strobe;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int rd0, s0, w, rate;
        bit got;

        tbl[0] = '{5, 3, 32'h1234_ABCD, 0, 1'b0, 16'd0, 16'h0000, 16'h0000, 1'b0};
        tbl[1] = '{1, 1, 32'h1234_ABCD, 1, 1'b1, 16'd0, 16'hABCD, 16'h1234, 1'b1};
        tbl[2] = '{3, 0, 32'h0,         3, 1'b1, 16'd0, 16'hABCD, 16'h1234, 1'b1};
`ifdef AUDIO_FADE_EN
        tbl[3] = '{3, 0, 32'h0,         0, 1'b0, 16'd3, 16'hF579, 16'h0246, 1'b0};
`else
        tbl[3] = '{3, 0, 32'h0,         0, 1'b0, 16'd3, 16'hABCD, 16'h1234, 1'b0};
`endif
        tbl[4] = '{1, 1, 32'h5555_6666, 1, 1'b1, 16'd3, 16'h6666, 16'h5555, 1'b1};
        tbl[5] = '{1, 1, 32'h8000_7FFF, 1, 1'b1, 16'd3, 16'h7FFF, 16'h8000, 1'b1};
`ifdef AUDIO_FADE_EN
        tbl[6] = '{1, 0, 32'h0,         0, 1'b0, 16'd4, 16'h3FFF, 16'hC000, 1'b0};
`else
        tbl[6] = '{1, 0, 32'h0,         0, 1'b0, 16'd4, 16'h7FFF, 16'h8000, 1'b0};
`endif

        reset_n = 1'b0; enable = 1'b0; fifo_q = '0; fifo_empty = 1'b1; fifo_level = '0;

        // Reset values.
        rst_drv = 1'b0;
        step(1'b0);
        step(1'b0);
        @(posedge clk_pixel);
        #1;
        chk("rst_playing", {31'b0, playing}, 32'd0);
        chk("rst_strobe",  {31'b0, sample_strobe}, 32'd0);
        chk("rst_left",    {16'b0, sample_left}, 32'd0);
        chk("rst_right",   {16'b0, sample_right}, 32'd0);
        chk("rst_count",   {16'b0, underrun_count}, 32'd0);
        chk("rst_clk",     {31'b0, clk_audio}, 32'd0);
        chk("rst_rden",    {31'b0, fifo_rden}, 32'd0);
        rst_drv = 1'b1;

        // Prefill gating, playback, underrun and refill.
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < tbl[i].push_n; j++) fq.push_back(tbl[i].word);
            rd0 = rd_seen;
            run_ticks(tbl[i].ticks, 1'b1);
            chk($sformatf("row%0d_rd", i),     rd_seen - rd0, tbl[i].exp_rd);
            chk($sformatf("row%0d_play", i),   {31'b0, playing}, {31'b0, tbl[i].exp_play});
            chk($sformatf("row%0d_count", i),  {16'b0, underrun_count}, {16'b0, tbl[i].exp_cnt});
            chk($sformatf("row%0d_left", i),   {16'b0, sample_left}, {16'b0, tbl[i].exp_l});
            chk($sformatf("row%0d_right", i),  {16'b0, sample_right}, {16'b0, tbl[i].exp_r});
            chk($sformatf("row%0d_strobe", i), {31'b0, sample_strobe}, {31'b0, tbl[i].exp_strobe});
        end

        // Saturation: preset the counter near the top while starved.
        force dut.underrun_count_q = 16'hFFFE;
        m_count = 16'hFFFE;
        step(1'b1);
        @(posedge clk_pixel);
        #1;
        release dut.underrun_count_q;
        run_ticks(3, 1'b1);
        chk("sat_count", {16'b0, underrun_count}, 32'h0000_FFFF);

        // Enable dropped on the tick cycle: no read, samples cleared.
        for (int j = 0; j < 6; j++) fq.push_back($urandom);
        run_ticks(1, 1'b1);
        chk("dis_pre_play", {31'b0, playing}, 32'd1);
        while (m_cnt != DIV - 1) step(1'b1);
        rd0 = rd_seen;
        s0  = strobe_seen;
        step(1'b0);
        chk("dis_tick_rden", rd_seen - rd0, 32'd0);
        step(1'b0);
        @(posedge clk_pixel);
        #1;
        chk("dis_playing", {31'b0, playing}, 32'd0);
        chk("dis_left",    {16'b0, sample_left}, 32'd0);
        chk("dis_right",   {16'b0, sample_right}, 32'd0);
        chk("dis_strobe_n", strobe_seen - s0, 32'd0);

        // Enable dropped while a read is in flight: data discarded, no strobe.
        rd0 = rd_seen;
        got = 1'b0;
        for (int c = 0; c < 4 * DIV && !got; c++) begin
            step(1'b1);
            got = (rd_seen != rd0);
        end
        chk("inflight_rd_seen", {31'b0, got}, 32'd1);
        s0 = strobe_seen;
        step(1'b0);
        step(1'b0);
        step(1'b0);
        @(posedge clk_pixel);
        #1;
        chk("inflight_strobe_n", strobe_seen - s0, 32'd0);
        chk("inflight_left",     {16'b0, sample_left}, 32'd0);
        chk("inflight_right",    {16'b0, sample_right}, 32'd0);
        chk("inflight_playing",  {31'b0, playing}, 32'd0);

        // Reset while a read is in flight, then clk_audio shape.
        for (int j = 0; j < 6; j++) fq.push_back($urandom);
        run_ticks(2, 1'b1);
        chk("prerst_play", {31'b0, playing}, 32'd1);
        rd0 = rd_seen;
        got = 1'b0;
        for (int c = 0; c < 4 * DIV && !got; c++) begin
            step(1'b1);
            got = (rd_seen != rd0);
        end
        chk("prerst_rd_seen", {31'b0, got}, 32'd1);
        rst_drv = 1'b0;
        step(1'b1);
        rst_drv = 1'b1;
        @(posedge clk_pixel);
        #1;
        chk("midrst_playing", {31'b0, playing}, 32'd0);
        chk("midrst_strobe",  {31'b0, sample_strobe}, 32'd0);
        chk("midrst_left",    {16'b0, sample_left}, 32'd0);
        chk("midrst_right",   {16'b0, sample_right}, 32'd0);
        chk("midrst_count",   {16'b0, underrun_count}, 32'd0);
        chk("midrst_clk",     {31'b0, clk_audio}, 32'd0);
        hi_seen = 0; rise_seen = 0; clk_prev = 1'b0;
        for (int c = 0; c < 2 * DIV; c++) step(1'b1);
        chk("clk_high_cycles", hi_seen, 2 * (DIV / 2));
        chk("clk_rises",       rise_seen, 32'd2);

        // Randomized traffic at three feed rates, with rare disables and resets.
        for (int seg = 0; seg < 3; seg++) begin
            rate = (seg == 0) ? 5 : (seg == 1) ? 20 : 40;
            for (int c = 0; c < 600; c++) begin
                if ($urandom_range(0, 99) < rate && fq.size() < 16) begin
                    w = $urandom;
                    fq.push_back(w);
                end
                rst_drv = ($urandom_range(0, 499) != 0);
                step($urandom_range(0, 63) != 0);
            end
        end
        rst_drv = 1'b1;
        step(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_sample_pacer.md
AUDIO_SAMPLE_PACER -- requirements
Module: audio_sample_pacer

Interface
REQ-001 SHALL have parameter DIV, default 1562, meaning clk_pixel cycles per audio sample period (75 MHz to ~48 kHz).
REQ-002 SHALL have parameter PREFILL, default 256, meaning the FIFO word count required before playback starts.
REQ-003 SHALL have parameter LEVEL_W, default 11, meaning the width of the FIFO level input.
REQ-004 clk_pixel  input  1  sole clock; all logic is on its rising edge.
REQ-005 reset_n  input  1  reset, synchronous and active-low.
REQ-006 enable  input  1  playback enable; low forces IDLE.
REQ-007 fifo_q  input  32  FIFO read data; [31:16] is right, [15:0] is left.
REQ-008 fifo_empty  input  1  FIFO empty flag.
REQ-009 fifo_level  input  LEVEL_W  FIFO occupied word count.
REQ-010 fifo_rden  output  1  FIFO read enable, one-cycle pulse.
REQ-011 clk_audio  output  1  derived sample clock for the HDMI audio port.
REQ-012 sample_left, sample_right  output  16 each  current sample words.
REQ-013 sample_strobe  output  1  one-cycle pulse when the sample words update.
REQ-014 underrun_count  output  16  saturating count of sample periods with no data.
REQ-015 playing  output  1  high in state PLAY.

Function
REQ-016 Divider counter SHALL count 0..DIV-1 and wrap to 0; tick is high on the cycle where counter==DIV-1.
REQ-017 clk_audio SHALL be registered high when counter >= DIV/2 (integer division), otherwise low.
REQ-018 States SHALL be IDLE, PLAY and UNDERRUN.
REQ-019 IDLE: outputs zero samples; on tick with enable=1 and fifo_level>=PREFILL -> PLAY and assert fifo_rden on that cycle.
REQ-020 PLAY, on tick with fifo_empty=0: assert fifo_rden and stay in PLAY.
REQ-021 PLAY, on tick with fifo_empty=1: no read; go to UNDERRUN; increment underrun_count.
REQ-022 UNDERRUN, on tick with fifo_empty=0: read and return to PLAY.
REQ-023 UNDERRUN, on tick with fifo_empty=1: stay in UNDERRUN; increment underrun_count.
REQ-024 FIFO read latency is 1: the cycle after fifo_rden, fifo_q SHALL be latched into sample_left/right and sample_strobe pulsed, giving 2 cycles from tick to sample update.
REQ-025 fifo_rden SHALL never be asserted while fifo_empty=1, and at most once per DIV cycles.
REQ-026 enable low in any state SHALL force IDLE on the next cycle and zero both samples; a read already in flight is discarded with no strobe.
REQ-027 underrun_count SHALL saturate at 16'hFFFF and hold.
REQ-028 On a tick coinciding with the enable falling edge, the disable SHALL win and no read is issued.
REQ-029 DIV < 4 is unsupported; behaviour is undefined.

Reset
REQ-030 With reset_n=0 at a rising edge, reset values SHALL be: state IDLE, counter 0, clk_audio 0, samples 0, fifo_rden 0, sample_strobe 0, underrun_count 0, playing 0.
REQ-031 Reset asserted mid-read SHALL discard the pending latch.

Configuration
REQ-032 Macro AUDIO_FADE_EN: when defined, each UNDERRUN tick SHALL arithmetic-shift both samples right by 1 (signed) and pulse sample_strobe, decaying toward 0 or -1.
REQ-033 Without AUDIO_FADE_EN, samples SHALL hold their last value in UNDERRUN and no strobe is pulsed.

Structure
REQ-034 Package audio_pkg SHALL hold the sample_t (16-bit signed) typedef, the state enum, and the DIV_720P=1562 and DIV_1080P=3125 constants.
REQ-035 Sub-module audio_tick_gen SHALL hold the divider counter, the tick and clk_audio.

Verification (bench DIV=8, PREFILL=4)
REQ-036 Idle gating: fifo_level=3 for 5 ticks -> no fifo_rden; level=4 -> rden on the next tick; sample valid 2 cycles after that tick.
REQ-037 Playback: FIFO preloaded with 32'h1234_ABCD -> sample_right=16'h1234 and sample_left=16'hABCD, strobe 1 cycle, playing=1.
REQ-038 Underrun: empty for 3 ticks -> underrun_count=3, samples held (fade build: 16'hABCD decays to 16'hD5E6, 16'hEAF3, 16'hF579); refill -> PLAY on the next tick.
REQ-039 Saturation: force underrun_count to 16'hFFFE and run 3 empty ticks -> count stays at 16'hFFFF.
REQ-040 Disable mid-read: enable dropped on the tick cycle -> no rden, no strobe, samples 0, IDLE.
REQ-041 Reset mid-PLAY: reset_n=0 for 1 cycle -> all outputs at reset values; clk_audio shows period 8 with 4 cycles high after release.
